// File: rtl/demux_1x2_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
// Used by the interface, the output slot and the top level.
package demux_pkg;

    localparam int   DATA_W_DEF = 8;
    localparam int   CNT_W_DEF  = 8;
    localparam logic SEL_OUT0   = 1'b0;
    localparam logic SEL_OUT1   = 1'b1;

endpackage : demux_pkg

// File: rtl/demux_1x2_stream_if.sv
// Stream bundle for the demultiplexer: one input stream, two output streams, counter access.
// The slave modport is the demux side; the master modport is the producer/consumer side.
interface demux_1x2_stream_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [DATA_W-1:0] in_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic              cnt_clr;
    logic [CNT_W-1:0]  out0_cnt;
    logic [CNT_W-1:0]  out1_cnt;

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready, cnt_clr,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_cnt, out1_cnt
    );

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready, cnt_clr,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, out0_cnt, out1_cnt
    );
endinterface : demux_1x2_stream_if

// File: rtl/demux_1x2_stream_slot.sv
// One-entry output register slice with valid flag, held payload and a wrapping count
// of beats handed to the consumer.
module stream_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_cnt
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              pop_s;

    assign pop_s = valid_q && out_ready;

    // Next-state: a push always wins, so pop+push keeps the slot full with no bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (pop_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (pop_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_cnt   = cnt_q;
endmodule : stream_slot

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer: each input beat is steered by in_sel into one of
// two one-entry output slots. Input is strictly in-order (head-of-line blocking by design).
module demux_1x2_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    demux_1x2_stream_if.slave  bus
);
    logic in_ready_s;
    logic push0_s;
    logic push1_s;

    // Ready looks only at the selected slot; it never depends on in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (bus.in_sel == SEL_OUT1) begin
            in_ready_s = !bus.out1_valid || bus.out1_ready;
        end else begin
            in_ready_s = !bus.out0_valid || bus.out0_ready;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign push0_s      = bus.in_valid && in_ready_s && (bus.in_sel == SEL_OUT0);
    assign push1_s      = bus.in_valid && in_ready_s && (bus.in_sel == SEL_OUT1);

    stream_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0_s),
        .push_data (bus.in_data),
        .out_ready (bus.out0_ready),
        .cnt_clr   (bus.cnt_clr),
        .out_valid (bus.out0_valid),
        .out_data  (bus.out0_data),
        .out_cnt   (bus.out0_cnt)
    );

    stream_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1_s),
        .push_data (bus.in_data),
        .out_ready (bus.out1_ready),
        .cnt_clr   (bus.cnt_clr),
        .out_valid (bus.out1_valid),
        .out_data  (bus.out1_data),
        .out_cnt   (bus.out1_cnt)
    );
endmodule : demux_1x2_stream
